count_rollover_tracker: RTL and testbench
=========================================

COUNT_ROLLOVER_TRACKER -- requirements
Module: count_rollover_tracker

Interface
REQ-001 The block SHALL have parameter WRAP_W, default 8, giving the width of the wrap counter.
REQ-002 The block SHALL have input clk, 1 bit: single clock, with all state updated on the rising edge.
REQ-003 The block SHALL have input rst, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have input count, 4 bits: value from the upstream binary up counter.
REQ-005 The block SHALL have input load, 1 bit: the same load strobe the upstream counter receives.
REQ-006 The block SHALL have input match_val, 4 bits: compare value.
REQ-007 The block SHALL have input clr, 1 bit: synchronous soft clear.
REQ-008 The block SHALL have output wrap_tick, 1 bit: one-cycle pulse on each 15->0 rollover.
REQ-009 The block SHALL have output wrap_cnt, WRAP_W bits: number of rollovers seen.
REQ-010 The block SHALL have output match_tick, 1 bit: one-cycle pulse when count newly equals match_val.
REQ-011 The block SHALL have output match_flag, 1 bit: sticky match indicator.
REQ-012 The block SHALL have output err_flag, 1 bit: sticky indicator for an illegal count step.
REQ-013 The block SHALL have output state, 2 bits: FSM state, with IDLE=0, TRACK=1, SAT=2.

Function
REQ-014 Internal registers SHALL be prev (the previous count sample) and load_q (the previous load value), both updated every cycle outside reset and clear.
REQ-015 A legal step SHALL be any of: count==prev (hold), count==prev+1 mod 16, or load_q==1 (upstream counter reload, any value).
REQ-016 A wrap SHALL be detected when prev==4'hF, count==4'h0 and load_q==0.
REQ-017 In IDLE, the block SHALL only capture prev and load_q, with no detection and no pulses, and SHALL move to TRACK on the next edge.
REQ-018 In TRACK, a detected wrap SHALL set wrap_tick=1 for exactly one cycle, registered with one-cycle latency after the sample, and SHALL increment wrap_cnt on the same edge.
REQ-019 In TRACK and SAT, when count==match_val and (count!=prev or load_q==1), the block SHALL set match_tick=1 for one cycle and set match_flag.
REQ-020 In TRACK and SAT, an illegal step SHALL set err_flag, and SHALL neither count as a wrap nor block a match.
REQ-021 The sticky flags match_flag and err_flag SHALL hold until rst or clr.
REQ-022 When clr is asserted, the block SHALL on that edge zero wrap_cnt, both sticky flags and both ticks, and move to IDLE.
REQ-023 rst SHALL have priority over clr, and clr SHALL have priority over all detection in the same cycle.
REQ-024 Simultaneous wrap and match in one cycle SHALL assert both wrap_tick and match_tick.
REQ-025 A load in the same cycle as a 15->0 transition SHALL produce no wrap, because load_q governs the following sample.

Reset
REQ-026 When rst is asserted on a clk edge, the block SHALL set wrap_tick=0, wrap_cnt=0, match_tick=0, match_flag=0, err_flag=0, prev=0, load_q=0 and state=IDLE.
REQ-027 Reset asserted mid-operation SHALL discard all history, and detection SHALL resume only after the IDLE cycle that follows reset release.

Configuration
REQ-028 When ROLLOVER_SAT_EN is defined, wrap_cnt SHALL saturate at all-ones: on reaching it, state moves TRACK->SAT, wrap_cnt holds, and wrap_tick still pulses on each wrap; only rst or clr leaves SAT.
REQ-029 When ROLLOVER_SAT_EN is undefined, wrap_cnt SHALL wrap modulo 2^WRAP_W, SAT SHALL be unreachable, and state SHALL never equal 2.

Verification
REQ-030 Scenario: rst held 2 cycles, then free-running count from 0 -> all outputs 0 during reset; state=IDLE one cycle, then TRACK.
REQ-031 Scenario: count 13,14,15,0 -> exactly one wrap_tick, one cycle after the 0 sample; wrap_cnt=1.
REQ-032 Scenario: load=1 with din=13 while count=15, next count=13 -> no wrap_tick, err_flag stays 0; then 13,14,15,0 gives wrap_cnt+1.
REQ-033 Scenario: match_val=4'd7, count 6,7,7,8 -> single match_tick on the first 7; match_flag=1 until clr.
REQ-034 Scenario: count jump 3->9 with load_q=0 -> err_flag=1; clr pulse -> err_flag=0, wrap_cnt=0, state=IDLE.
REQ-035 Scenario: WRAP_W=2 with 5 wraps -> with ROLLOVER_SAT_EN, wrap_cnt=3 and state=SAT; without it, wrap_cnt=1 and state=TRACK.

Source files
------------

// File: rtl/count_rollover_tracker.sv
// Tracks 15->0 rollovers and compare matches of an upstream 4-bit up counter, and flags illegal steps.
// Define ROLLOVER_SAT_EN to make wrap_cnt saturate at all-ones, which parks the FSM in SAT.
module count_rollover_tracker #(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        count,
  input  logic              load,
  input  logic [3:0]        match_val,
  input  logic              clr,
  output logic              wrap_tick,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              match_tick,
  output logic              match_flag,
  output logic              err_flag,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StTrack = 2'd1,
    StSat   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic              load_q, load_d;
  logic              wrap_tick_q, wrap_tick_d;
  logic              match_tick_q, match_tick_d;
  logic              match_flag_q, match_flag_d;
  logic              err_flag_q, err_flag_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

  logic [3:0] prev_inc;
  logic       step_legal;
  logic       wrap_det;
  logic       match_det;

  // A reload may land on any value, so load_q excuses the step and suppresses the wrap.
  assign prev_inc   = prev_q + 4'd1;
  assign step_legal = (count == prev_q) || (count == prev_inc) || load_q;
  assign wrap_det   = (prev_q == 4'hF) && (count == 4'h0) && !load_q;
  assign match_det  = (count == match_val) && ((count != prev_q) || load_q);

  always_comb begin
    state_d      = state_q;
    prev_d       = count;
    load_d       = load;
    wrap_tick_d  = 1'b0;
    match_tick_d = 1'b0;
    match_flag_d = match_flag_q;
    err_flag_d   = err_flag_q;
    wrap_cnt_d   = wrap_cnt_q;

    if (clr) begin
      prev_d       = prev_q;
      load_d       = load_q;
      match_flag_d = 1'b0;
      err_flag_d   = 1'b0;
      wrap_cnt_d   = '0;
      state_d      = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StTrack;
        end
        StTrack, StSat: begin
          if (wrap_det) begin
            wrap_tick_d = 1'b1;
`ifdef ROLLOVER_SAT_EN
            if (state_q == StTrack) begin
              wrap_cnt_d = wrap_cnt_q + {{(WRAP_W-1){1'b0}}, 1'b1};
              if (&wrap_cnt_d) begin
                state_d = StSat;
              end
            end
`else
            wrap_cnt_d = wrap_cnt_q + {{(WRAP_W-1){1'b0}}, 1'b1};
`endif
          end
          if (match_det) begin
            match_tick_d = 1'b1;
            match_flag_d = 1'b1;
          end
          if (!step_legal) begin
            err_flag_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      prev_q       <= 4'd0;
      load_q       <= 1'b0;
      wrap_tick_q  <= 1'b0;
      match_tick_q <= 1'b0;
      match_flag_q <= 1'b0;
      err_flag_q   <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      load_q       <= load_d;
      wrap_tick_q  <= wrap_tick_d;
      match_tick_q <= match_tick_d;
      match_flag_q <= match_flag_d;
      err_flag_q   <= err_flag_d;
      wrap_cnt_q   <= wrap_cnt_d;
    end
  end

  assign wrap_tick  = wrap_tick_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign match_tick = match_tick_q;
  assign match_flag = match_flag_q;
  assign err_flag   = err_flag_q;
  assign state      = state_q;

endmodule

// File: tb/tb_count_rollover_tracker.sv
// Directed scoreboard bench for count_rollover_tracker, built with WRAP_W=2 so saturation and
// modulo wrap both show up within a handful of rollovers.
module tb_count_rollover_tracker;

  localparam int unsigned WW = 2;
  localparam logic [1:0] SI = 2'd0;
  localparam logic [1:0] ST = 2'd1;
`ifdef ROLLOVER_SAT_EN
  localparam logic [1:0] SH   = 2'd2;
  localparam logic [1:0] CNT4 = 2'd3;
  localparam logic [1:0] CNT5 = 2'd3;
`else
  localparam logic [1:0] SH   = 2'd1;
  localparam logic [1:0] CNT4 = 2'd0;
  localparam logic [1:0] CNT5 = 2'd1;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    count = 4'd0;
  logic          load = 1'b0;
  logic [3:0]    match_val = 4'd5;
  logic          clr = 1'b0;
  logic          wrap_tick;
  logic [WW-1:0] wrap_cnt;
  logic          match_tick;
  logic          match_flag;
  logic          err_flag;
  logic [1:0]    state;

  count_rollover_tracker #(.WRAP_W(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .count      (count),
    .load       (load),
    .match_val  (match_val),
    .clr        (clr),
    .wrap_tick  (wrap_tick),
    .wrap_cnt   (wrap_cnt),
    .match_tick (match_tick),
    .match_flag (match_flag),
    .err_flag   (err_flag),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Packed as {wrap_tick, wrap_cnt, match_tick, match_flag, err_flag, state}.
  typedef struct {
    string      name;
    logic [7:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic step(input string name, input bit r, input bit c, input bit ld,
                      input logic [3:0] cnt_in, input logic [3:0] mv,
                      input bit wt, input logic [1:0] wc, input bit mt, input bit mf,
                      input bit ef, input logic [1:0] st);
    exp_t e;
    rst       = r;
    clr       = c;
    load      = ld;
    count     = cnt_in;
    match_val = mv;
    e.name    = name;
    e.v       = {wt, wc, mt, mf, ef, st};
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: every edge the DUT presents a new registered output set.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {wrap_tick, wrap_cnt, match_tick, match_flag, err_flag, state};
        checks++;
        if (act !== e.v) begin
          failures++;
          $display("FAIL %s: got wt=%b cnt=%0d mt=%b mf=%b ef=%b st=%0d, want wt=%b cnt=%0d mt=%b mf=%b ef=%b st=%0d",
                   e.name, act[7], act[6:5], act[4], act[3], act[2], act[1:0],
                   e.v[7], e.v[6:5], e.v[4], e.v[3], e.v[2], e.v[1:0]);
        end
      end
    end
  end

  initial begin
    #2;
    //    name             r  c  ld cnt   mv    wt wc    mt mf ef st
    step("rst0",           1, 0, 0, 4'd0, 4'd5, 0, 2'd0, 0, 0, 0, SI);
    step("rst1",           1, 0, 0, 4'd0, 4'd5, 0, 2'd0, 0, 0, 0, SI);
    step("idle_exit",      0, 0, 0, 4'd0, 4'd5, 0, 2'd0, 0, 0, 0, ST);
    step("run1",           0, 0, 0, 4'd1, 4'd5, 0, 2'd0, 0, 0, 0, ST);
    step("run2",           0, 0, 0, 4'd2, 4'd5, 0, 2'd0, 0, 0, 0, ST);
    step("run3",           0, 0, 0, 4'd3, 4'd5, 0, 2'd0, 0, 0, 0, ST);
    step("hold3",          0, 0, 0, 4'd3, 4'd5, 0, 2'd0, 0, 0, 0, ST);
    step("load_a",         0, 0, 1, 4'd3, 4'd5, 0, 2'd0, 0, 0, 0, ST);
    step("reload13",       0, 0, 0, 4'd13, 4'd5, 0, 2'd0, 0, 0, 0, ST);
    step("w1_14",          0, 0, 0, 4'd14, 4'd5, 0, 2'd0, 0, 0, 0, ST);
    step("w1_15",          0, 0, 0, 4'd15, 4'd5, 0, 2'd0, 0, 0, 0, ST);
    step("wrap1",          0, 0, 0, 4'd0, 4'd5, 1, 2'd1, 0, 0, 0, ST);
    step("wrap1_after",    0, 0, 0, 4'd1, 4'd5, 0, 2'd1, 0, 0, 0, ST);
    step("load_b",         0, 0, 1, 4'd1, 4'd5, 0, 2'd1, 0, 0, 0, ST);
    step("reload15",       0, 0, 0, 4'd15, 4'd5, 0, 2'd1, 0, 0, 0, ST);
    step("load_at15",      0, 0, 1, 4'd15, 4'd5, 0, 2'd1, 0, 0, 0, ST);
    step("reload13_noerr", 0, 0, 0, 4'd13, 4'd5, 0, 2'd1, 0, 0, 0, ST);
    step("w2_14",          0, 0, 0, 4'd14, 4'd5, 0, 2'd1, 0, 0, 0, ST);
    step("w2_15",          0, 0, 0, 4'd15, 4'd5, 0, 2'd1, 0, 0, 0, ST);
    step("wrap2",          0, 0, 0, 4'd0, 4'd5, 1, 2'd2, 0, 0, 0, ST);
    step("wrap2_after",    0, 0, 0, 4'd1, 4'd5, 0, 2'd2, 0, 0, 0, ST);
    step("load_c",         0, 0, 1, 4'd1, 4'd5, 0, 2'd2, 0, 0, 0, ST);
    step("reload15b",      0, 0, 0, 4'd15, 4'd5, 0, 2'd2, 0, 0, 0, ST);
    step("load_at15b",     0, 0, 1, 4'd15, 4'd5, 0, 2'd2, 0, 0, 0, ST);
    step("load_zero_nowrp",0, 0, 0, 4'd0, 4'd5, 0, 2'd2, 0, 0, 0, ST);
    step("load_d",         0, 0, 1, 4'd0, 4'd7, 0, 2'd2, 0, 0, 0, ST);
    step("m_6",            0, 0, 0, 4'd6, 4'd7, 0, 2'd2, 0, 0, 0, ST);
    step("m_7_first",      0, 0, 0, 4'd7, 4'd7, 0, 2'd2, 1, 1, 0, ST);
    step("m_7_hold",       0, 0, 0, 4'd7, 4'd7, 0, 2'd2, 0, 1, 0, ST);
    step("m_8",            0, 0, 0, 4'd8, 4'd7, 0, 2'd2, 0, 1, 0, ST);
    step("load_e",         0, 0, 1, 4'd8, 4'd0, 0, 2'd2, 0, 1, 0, ST);
    step("reload15c",      0, 0, 0, 4'd15, 4'd0, 0, 2'd2, 0, 1, 0, ST);
    step("wrap3_match",    0, 0, 0, 4'd0, 4'd0, 1, 2'd3, 1, 1, 0, SH);
    step("w3_after",       0, 0, 0, 4'd1, 4'd9, 0, 2'd3, 0, 1, 0, SH);
    step("load_f",         0, 0, 1, 4'd1, 4'd9, 0, 2'd3, 0, 1, 0, SH);
    step("reload15d",      0, 0, 0, 4'd15, 4'd9, 0, 2'd3, 0, 1, 0, SH);
    step("wrap4",          0, 0, 0, 4'd0, 4'd9, 1, CNT4, 0, 1, 0, SH);
    step("w4_after",       0, 0, 0, 4'd1, 4'd9, 0, CNT4, 0, 1, 0, SH);
    step("load_g",         0, 0, 1, 4'd1, 4'd9, 0, CNT4, 0, 1, 0, SH);
    step("reload15e",      0, 0, 0, 4'd15, 4'd9, 0, CNT4, 0, 1, 0, SH);
    step("wrap5",          0, 0, 0, 4'd0, 4'd9, 1, CNT5, 0, 1, 0, SH);
    step("w5_after",       0, 0, 0, 4'd1, 4'd9, 0, CNT5, 0, 1, 0, SH);
    step("e_2",            0, 0, 0, 4'd2, 4'd9, 0, CNT5, 0, 1, 0, SH);
    step("e_3",            0, 0, 0, 4'd3, 4'd9, 0, CNT5, 0, 1, 0, SH);
    step("jump_3_9",       0, 0, 0, 4'd9, 4'd9, 0, CNT5, 1, 1, 1, SH);
    step("err_sticky",     0, 0, 0, 4'd10, 4'd9, 0, CNT5, 0, 1, 1, SH);
    step("clr",            0, 1, 0, 4'd11, 4'd9, 0, 2'd0, 0, 0, 0, SI);
    step("clr_idle",       0, 0, 0, 4'd12, 4'd9, 0, 2'd0, 0, 0, 0, ST);
    step("post_clr_13",    0, 0, 0, 4'd13, 4'd9, 0, 2'd0, 0, 0, 0, ST);
    step("post_clr_14",    0, 0, 0, 4'd14, 4'd9, 0, 2'd0, 0, 0, 0, ST);
    step("post_clr_15",    0, 0, 0, 4'd15, 4'd9, 0, 2'd0, 0, 0, 0, ST);
    step("clr_over_wrap",  0, 1, 0, 4'd0, 4'd9, 0, 2'd0, 0, 0, 0, SI);
    step("idle_no_detect", 0, 0, 0, 4'd0, 4'd9, 0, 2'd0, 0, 0, 0, ST);
    step("err_0_5",        0, 0, 0, 4'd5, 4'd9, 0, 2'd0, 0, 0, 1, ST);
    step("rst_over_clr",   1, 1, 0, 4'd5, 4'd9, 0, 2'd0, 0, 0, 0, SI);
    step("rst_idle",       0, 0, 0, 4'd15, 4'd9, 0, 2'd0, 0, 0, 0, ST);
    step("rst_wrap",       0, 0, 0, 4'd0, 4'd9, 1, 2'd1, 0, 0, 0, ST);
    step("rst_wrap_after", 0, 0, 0, 4'd0, 4'd9, 0, 2'd1, 0, 0, 0, ST);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
